icache_dm: RTL and testbench

- Parametrised direct-mapped instruction cache: one per hardware thread, sitting between a thread's PC fetch path and the shared slow memory.
- Supplies one instruction word per cycle on a hit.
- On a miss it runs a strobe/rnotw/mfc read handshake with slow memory, gated by an external grant from the memory arbiter, and fills the line.
- Generalises the per-thread fetch cache to configurable depth, miss word and miss timeout/retry.

---
 rtl/icache_dm.sv | 178 +++++++++++++++++
 tb/tb_icache_dm.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache with a strobe/rnotw/mfc miss handshake to slow memory.
// Optional snoop invalidation of lines hit by data-side writes is enabled by defining ICACHE_SNOOP_EN.
module icache_dm #(
    parameter int          LINES     = 8,
    parameter logic [15:0] MISS_WORD = 16'hFFFF,
    parameter int          TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [15:0] addr,
    output logic [15:0] instr,
    output logic        hit,
    output logic        busy,
    input  logic        mem_grant,
    output logic        mem_strobe,
    output logic        mem_rnotw,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_mfc,
    input  logic        snoop_strobe,
    input  logic        snoop_rnotw,
    input  logic [15:0] snoop_addr,
    output logic [7:0]  retries
);

    localparam int          IDX_W     = $clog2(LINES);
    localparam int          TAG_W     = 16 - IDX_W;
    localparam logic [7:0]  TMO_LIMIT = 8'(TIMEOUT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]       state_r;
    logic [15:0]      miss_addr_r;
    logic [LINES-1:0] valid_r;
    logic [TAG_W-1:0] tag_r  [LINES];
    logic [15:0]      data_r [LINES];
    logic [7:0]       tmo_cnt_r;
    logic [7:0]       retries_r;
    logic             mem_strobe_r;
    logic             mem_rnotw_r;
    logic [15:0]      mem_addr_r;

    logic [IDX_W-1:0] idx_s;
    logic [TAG_W-1:0] tag_s;
    logic [IDX_W-1:0] miss_idx_s;
    logic [TAG_W-1:0] miss_tag_s;
    logic             fill_s;
    logic             hit_s;
    logic [15:0]      instr_s;

    assign idx_s      = addr[IDX_W-1:0];
    assign tag_s      = addr[15:IDX_W];
    assign miss_idx_s = miss_addr_r[IDX_W-1:0];
    assign miss_tag_s = miss_addr_r[15:IDX_W];
    assign fill_s     = (state_r == ST_WAIT) && mem_mfc;

    // Zero-latency lookup; the WAIT bypass forwards returning fill data to a matching fetch.
    always_comb begin
        hit_s   = 1'b0;
        instr_s = MISS_WORD;
        if (req && (state_r == ST_IDLE) && valid_r[idx_s] && (tag_r[idx_s] == tag_s)) begin
            hit_s   = 1'b1;
            instr_s = data_r[idx_s];
        end else if (req && fill_s && (addr == miss_addr_r)) begin
            hit_s   = 1'b1;
            instr_s = mem_rdata;
        end else begin
            hit_s   = 1'b0;
            instr_s = MISS_WORD;
        end
    end

`ifdef ICACHE_SNOOP_EN
    logic [IDX_W-1:0] snoop_idx_s;
    logic             snoop_clr_s;

    assign snoop_idx_s = snoop_addr[IDX_W-1:0];
    assign snoop_clr_s = snoop_strobe && !snoop_rnotw && valid_r[snoop_idx_s]
                         && (tag_r[snoop_idx_s] == snoop_addr[15:IDX_W]);
`else
    logic snoop_unused_s;

    assign snoop_unused_s = ^{snoop_strobe, snoop_rnotw, snoop_addr};
`endif

    // Miss FSM: latch the miss, wait for grant, pulse the strobe, then wait for mfc or time out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            miss_addr_r  <= 16'h0000;
            tmo_cnt_r    <= 8'd0;
            retries_r    <= 8'd0;
            mem_strobe_r <= 1'b0;
            mem_rnotw_r  <= 1'b0;
            mem_addr_r   <= 16'h0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    mem_strobe_r <= 1'b0;
                    mem_rnotw_r  <= 1'b0;
                    if (req && !hit_s) begin
                        miss_addr_r <= addr;
                        state_r     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_grant) begin
                        mem_strobe_r <= 1'b1;
                        mem_rnotw_r  <= 1'b1;
                        mem_addr_r   <= miss_addr_r;
                        tmo_cnt_r    <= 8'd0;
                        state_r      <= ST_WAIT;
                    end else begin
                        mem_strobe_r <= 1'b0;
                        mem_rnotw_r  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    mem_strobe_r <= 1'b0;
                    mem_rnotw_r  <= 1'b0;
                    if (mem_mfc) begin
                        state_r <= ST_IDLE;
                    end else if (tmo_cnt_r == TMO_LIMIT) begin
                        // Counter has already spent TIMEOUT cycles past the strobe cycle: re-issue.
                        tmo_cnt_r <= 8'd0;
                        state_r   <= ST_REQ;
                        if (retries_r != 8'hFF) begin
                            retries_r <= retries_r + 8'd1;
                        end
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    mem_strobe_r <= 1'b0;
                    mem_rnotw_r  <= 1'b0;
                end
            endcase
        end
    end

    // Valid bits: snoop clears first so a same-index fill in the same cycle wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r <= '0;
        end else begin
`ifdef ICACHE_SNOOP_EN
            if (snoop_clr_s) begin
                valid_r[snoop_idx_s] <= 1'b0;
            end
`endif
            if (fill_s) begin
                valid_r[miss_idx_s] <= 1'b1;
            end
        end
    end

    // Tag and data storage needs no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill_s) begin
            tag_r[miss_idx_s]  <= miss_tag_s;
            data_r[miss_idx_s] <= mem_rdata;
        end
    end

    assign hit        = hit_s;
    assign instr      = instr_s;
    assign busy       = (state_r != ST_IDLE);
    assign mem_strobe = mem_strobe_r;
    assign mem_rnotw  = mem_rnotw_r;
    assign mem_addr   = mem_addr_r;
    assign retries    = retries_r;

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm (LINES=8, TIMEOUT=3): cold/conflict misses, grant stall,
// timeout re-issue, reset mid-miss and snoop invalidation (expectation follows ICACHE_SNOOP_EN).
module tb_icache_dm;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [15:0] addr;
    logic [15:0] instr;
    logic        hit;
    logic        busy;
    logic        mem_grant;
    logic        mem_strobe;
    logic        mem_rnotw;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_mfc;
    logic        snoop_strobe;
    logic        snoop_rnotw;
    logic [15:0] snoop_addr;
    logic [7:0]  retries;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

`ifdef ICACHE_SNOOP_EN
    localparam logic SNOOP_ON = 1'b1;
`else
    localparam logic SNOOP_ON = 1'b0;
`endif

    icache_dm #(.LINES(8), .MISS_WORD(16'hFFFF), .TIMEOUT(3)) dut (
        .clk(clk), .reset(reset), .req(req), .addr(addr), .instr(instr), .hit(hit), .busy(busy),
        .mem_grant(mem_grant), .mem_strobe(mem_strobe), .mem_rnotw(mem_rnotw), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_mfc(mem_mfc), .snoop_strobe(snoop_strobe),
        .snoop_rnotw(snoop_rnotw), .snoop_addr(snoop_addr), .retries(retries)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req = 1'b0; addr = 16'h0000; mem_grant = 1'b0; mem_rdata = 16'h0000;
        mem_mfc = 1'b0; snoop_strobe = 1'b0; snoop_rnotw = 1'b1; snoop_addr = 16'h0000;
        #1;
        chk("rst_hit", 16'(hit), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_instr", instr, 16'hFFFF);
        chk("rst_strobe", 16'(mem_strobe), 16'd0);
        chk("rst_rnotw", 16'(mem_rnotw), 16'd0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_retries", 16'(retries), 16'd0);
        cyc(); cyc();
        reset = 1'b0;

        // cold miss on 0x0003
        cyc(); req = 1'b1; addr = 16'h0003; mem_grant = 1'b1; #1;
        chk("cold_hit", 16'(hit), 16'd0);
        chk("cold_instr", instr, 16'hFFFF);
        chk("cold_busy0", 16'(busy), 16'd0);
        cyc(); #1;
        chk("cold_req_busy", 16'(busy), 16'd1);
        chk("cold_req_strobe", 16'(mem_strobe), 16'd0);
        cyc(); #1;
        chk("cold_strobe", 16'(mem_strobe), 16'd1);
        chk("cold_rnotw", 16'(mem_rnotw), 16'd1);
        chk("cold_mem_addr", mem_addr, 16'h0003);
        chk("cold_wait_hit", 16'(hit), 16'd0);
        cyc(); mem_mfc = 1'b1; mem_rdata = 16'h1234; #1;
        chk("cold_bypass_hit", 16'(hit), 16'd1);
        chk("cold_bypass_instr", instr, 16'h1234);
        chk("cold_bypass_strobe", 16'(mem_strobe), 16'd0);
        cyc(); mem_mfc = 1'b0; mem_rdata = 16'h0000; #1;
        chk("warm_hit", 16'(hit), 16'd1);
        chk("warm_instr", instr, 16'h1234);
        chk("warm_busy", 16'(busy), 16'd0);
        chk("warm_strobe", 16'(mem_strobe), 16'd0);

        // conflict: 0x000B shares index 3
        cyc(); addr = 16'h000B; #1;
        chk("conf_b_miss", 16'(hit), 16'd0);
        cyc(); cyc(); #1;
        chk("conf_b_strobe", 16'(mem_strobe), 16'd1);
        chk("conf_b_mem_addr", mem_addr, 16'h000B);
        cyc(); mem_mfc = 1'b1; mem_rdata = 16'hBEEF; #1;
        chk("conf_b_bypass", instr, 16'hBEEF);
        cyc(); mem_mfc = 1'b0; #1;
        chk("conf_b_hit", 16'(hit), 16'd1);
        chk("conf_b_instr", instr, 16'hBEEF);
        cyc(); addr = 16'h0003; #1;
        chk("conf_3_evicted", 16'(hit), 16'd0);
        cyc(); cyc(); #1;
        chk("conf_3_mem_addr", mem_addr, 16'h0003);
        chk("conf_3_strobe", 16'(mem_strobe), 16'd1);
        cyc(); mem_mfc = 1'b1; mem_rdata = 16'h1234;
        cyc(); mem_mfc = 1'b0; #1;
        chk("conf_3_refill", instr, 16'h1234);

        // grant stall
        cyc(); mem_grant = 1'b0; addr = 16'h000B; #1;
        chk("stall_miss", 16'(hit), 16'd0);
        for (int i = 0; i < 5; i++) begin
            cyc(); #1;
            chk("stall_busy", 16'(busy), 16'd1);
            chk("stall_no_strobe", 16'(mem_strobe), 16'd0);
        end
        cyc(); mem_grant = 1'b1; #1;
        chk("stall_grant_cycle", 16'(mem_strobe), 16'd0);
        cyc(); #1;
        chk("stall_strobe", 16'(mem_strobe), 16'd1);
        chk("stall_mem_addr", mem_addr, 16'h000B);
        cyc(); mem_mfc = 1'b1; mem_rdata = 16'hBEEF; #1;
        chk("stall_bypass", 16'(hit), 16'd1);
        cyc(); mem_mfc = 1'b0; #1;
        chk("stall_fill", instr, 16'hBEEF);

        // timeout re-issue every 5 cycles
        cyc(); addr = 16'h0003; #1;
        chk("tmo_miss", 16'(hit), 16'd0);
        cyc(); cyc(); #1;
        chk("tmo_strobe0", 16'(mem_strobe), 16'd1);
        chk("tmo_retries0", 16'(retries), 16'd0);
        for (int r = 1; r <= 3; r++) begin
            for (int k = 0; k < 4; k++) begin
                cyc(); #1;
                chk("tmo_gap", 16'(mem_strobe), 16'd0);
            end
            cyc(); #1;
            chk("tmo_reissue", 16'(mem_strobe), 16'd1);
            chk("tmo_reissue_addr", mem_addr, 16'h0003);
            chk("tmo_retries", 16'(retries), 16'(r));
        end
        cyc(); mem_mfc = 1'b1; mem_rdata = 16'h1234; #1;
        chk("tmo_late_bypass", instr, 16'h1234);
        cyc(); mem_mfc = 1'b0; #1;
        chk("tmo_fill_hit", 16'(hit), 16'd1);
        chk("tmo_retries_hold", 16'(retries), 16'd3);

        // reset two cycles after the strobe
        cyc(); addr = 16'h000B; #1;
        chk("rstw_miss", 16'(hit), 16'd0);
        cyc(); cyc(); #1;
        chk("rstw_strobe", 16'(mem_strobe), 16'd1);
        cyc(); cyc(); reset = 1'b1; #1;
        chk("rstw_busy", 16'(busy), 16'd0);
        chk("rstw_strobe0", 16'(mem_strobe), 16'd0);
        chk("rstw_hit", 16'(hit), 16'd0);
        chk("rstw_retries", 16'(retries), 16'd0);
        cyc(); reset = 1'b0; req = 1'b0; mem_mfc = 1'b1; mem_rdata = 16'hBEEF; #1;
        chk("rstw_mfc_idle_busy", 16'(busy), 16'd0);
        cyc(); mem_mfc = 1'b0; mem_rdata = 16'h0000; req = 1'b1; addr = 16'h000B; #1;
        chk("rstw_late_mfc_ignored", 16'(hit), 16'd0);
        cyc(); #1;
        chk("rstw_new_miss_busy", 16'(busy), 16'd1);
        cyc(); #1;
        chk("rstw_new_strobe", 16'(mem_strobe), 16'd1);
        cyc(); mem_mfc = 1'b1; mem_rdata = 16'hBEEF;
        cyc(); mem_mfc = 1'b0; addr = 16'h0003; #1;
        chk("rstw_fresh_miss", 16'(hit), 16'd0);
        chk("rstw_fresh_idle", 16'(busy), 16'd0);
        cyc(); cyc(); #1;
        chk("rstw_fresh_addr", mem_addr, 16'h0003);
        cyc(); mem_mfc = 1'b1; mem_rdata = 16'h1234;
        cyc(); mem_mfc = 1'b0; #1;
        chk("rstw_refill", instr, 16'h1234);

        // snoop writes
        snoop_strobe = 1'b1; snoop_rnotw = 1'b0; snoop_addr = 16'h000B; #1;
        chk("snoop_pre_hit", 16'(hit), 16'd1);
        cyc(); snoop_addr = 16'h0003; #1;
        chk("snoop_other_tag_keeps", 16'(hit), 16'd1);
        cyc(); snoop_strobe = 1'b0; snoop_rnotw = 1'b1; #1;
        chk("snoop_match_hit", 16'(hit), SNOOP_ON ? 16'd0 : 16'd1);
        cyc(); #1;
        chk("snoop_match_busy", 16'(busy), SNOOP_ON ? 16'd1 : 16'd0);
        req = 1'b0;
        cyc(); cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
